seven_seg_scan_ctrl: RTL and testbench
======================================

# seven_seg_scan_ctrl

Display controller for the 16-bit ALU result. Captures a 16-bit unsigned value on request and converts it to five BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto a five-digit common-anode seven-segment display. Each digit code is presented to the team's `seven_seg_decoder`, which blanks code 4'hF, so the controller blanks leading zeros by driving 4'hF.

## Interface
Parameters:
- `REFRESH_DIV`, 50000: clock cycles each digit stays enabled; legal range ≥1.
- `BLANK_LEADING`, 1: 1 = blank leading zeros; 0 = show all five digits.

Ports:
- `clk` input 1: single system clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `value_in` input 16: unsigned binary value to display; sampled only on an accepted `load`.
- `load` input 1: capture request; accepted only when `busy`=0.
- `busy` output 1: conversion in progress.
- `done` output 1: one-cycle pulse when the new value becomes visible.
- `digit_bin` output 4: BCD code for the enabled digit, or 4'hF for blank; feeds `seven_seg_decoder.bin`.
- `an_n` output 5: active-low digit enable, one-hot-low; bit 0 = least significant digit.

## Operation
- **Reset values:** display register = 20'h00000; digit index = 0; prescaler = 0; conversion FSM in IDLE.
  - Outputs: `busy`=0, `done`=0, `an_n`=5'b11110, `digit_bin`=4'h0.
- **Conversion FSM states:** IDLE, CONVERT.
  - IDLE→CONVERT on `load`=1. `value_in` is copied into the shift register, the BCD accumulator is cleared, and the iteration counter is set to 0.
  - In CONVERT, each cycle:
    - add 3 to every BCD nibble of the accumulator that is ≥5;
    - shift {accumulator, shift register} left by 1;
    - increment the counter.
  - After the 16th iteration: write the 20-bit accumulator to the display register, pulse `done`, and return to IDLE.
  - `load` while in CONVERT is ignored; there is no queueing.
- **Accumulator width:** 20 bits, 5 nibbles. Maximum input 65535 gives 20'h65535, so there is no overflow.
- **Scanner:**
  - The prescaler counts 0..REFRESH_DIV-1.
  - At terminal count it resets to 0 and the digit index advances 0→1→2→3→4→0.
  - With REFRESH_DIV=1 the index advances every cycle.
- **`an_n`:** bit [index] is 0 and all other bits are 1. It is registered and changes in the same cycle as the index.
- **`digit_bin`:** the display nibble at the current index. Exception: when `BLANK_LEADING`=1, index > 0, and that nibble and every higher nibble are 0, it is 4'hF.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Embedded zeros are shown, e.g. 10005 → "10005".
- The scanner runs continuously and is independent of conversion. The old value stays displayed during CONVERT. The display register changes atomically, so a torn digit set is never displayed.
- **Reset mid-conversion:** the conversion is aborted and the display register returns to 0. The captured value is discarded.

## Timing
- `load` sampled high in cycle N (IDLE): `busy`=1 in cycles N+1..N+16.
- In cycle N+17: `busy`=0, `done`=1 for that cycle only, and the display register holds the new BCD value.
- Total load-to-visible latency is 17 cycles.
  - A new `load` is accepted no earlier than cycle N+17. A `load` high in N+17 starts the next conversion.
- `digit_bin` and `an_n` are registered and mutually consistent every cycle. A display update in cycle N+17 takes effect on the currently enabled digit that same cycle, without waiting for a digit boundary.
- Digit period = REFRESH_DIV cycles; full refresh = 5×REFRESH_DIV cycles.

## Test plan
- **Reset:** hold `rst` for 3 cycles.
  - Required: `busy`=0, `done`=0, `an_n`=5'b11110, `digit_bin`=4'h0.
  - Scan with REFRESH_DIV=2: `an_n` steps 11110→11101→11011→10111→01111→11110, changing every 2 cycles; `digit_bin` = 0,F,F,F,F.
- **Load 12345:**
  - `busy` is high exactly 16 cycles and `done` pulses once in cycle 17.
  - Scanned `digit_bin` = 5,4,3,2,1 for digits 0..4.
- **Load 0, then 65535, then 10005:**
  - Scanned digits: 0,F,F,F,F; then 5,3,5,5,6; then 5,0,0,0,1.
  - With `BLANK_LEADING`=0, value 42 scans 2,4,0,0,0.
- **Load 777 and assert `load` with 999 in cycles N+3 and N+10:**
  - Required: only 777 is displayed, and `done` pulses once.
  - A `load` in N+17 with 999 is accepted; `done` pulses at N+34.
- **Load 500 after 12345 is displayed, assert `rst` in cycle N+8:**
  - Required: `busy`=0 and display 0,F,F,F,F after reset; no `done` pulse.
  - A subsequent load of 500 displays 0,0,5,F,F.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Converts a captured 16-bit unsigned value to five BCD digits with a
// sequential shift-add-3 (double-dabble) engine. The digits are then
// time-multiplexed onto a five-digit common-anode seven-segment display.
// Leading zeros can be blanked by driving code 4'hF, which the downstream
// seven_seg_decoder renders as an unlit digit.
//
// Parameters:
//   REFRESH_DIV   - clock cycles each digit stays enabled (>= 1)
//   BLANK_LEADING - 1: blank leading zeros, 0: show all five digits
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   value_in  in   [15:0] value to display, sampled on an accepted load
//   load      in   capture request, accepted only while busy = 0
//   busy      out  conversion in progress
//   done      out  one-cycle pulse when the new value becomes visible
//   digit_bin out  [3:0] BCD code of the enabled digit, 4'hF = blank
//   an_n      out  [4:0] active-low one-hot digit enable, bit 0 = LSD
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [3:0]  digit_bin,
  output logic [4:0]  an_n
);

  typedef enum logic {
    S_IDLE,
    S_CONVERT
  } state_e;

  // A one-bit prescaler is kept even for REFRESH_DIV = 1 so the vector is
  // never zero-width; the terminal count is then simply always reached.
  localparam int            PW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  state_e        state_q, state_d;
  logic [15:0]   shift_q, shift_d;
  logic [19:0]   acc_q,   acc_d;
  logic [3:0]    iter_q,  iter_d;
  logic [19:0]   disp_q,  disp_d;
  logic          done_q,  done_d;
  logic [PW-1:0] pre_q,   pre_d;
  logic [2:0]    idx_q,   idx_d;
  logic [4:0]    an_n_q,  an_n_d;
  logic [3:0]    digit_q, digit_d;

  logic [19:0]   acc_adj;
  logic [3:0]    nib;
  logic          lead_zero;

  // ---------------------------------------------------------------------------
  // Conversion engine
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    disp_d  = disp_q;
    done_d  = 1'b0;

    // Add-3 correction on every nibble >= 5 before the shift, so that the
    // doubling carries correctly into the next decimal digit.
    for (int i = 0; i < 5; i++) begin
      acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                    : acc_q[4*i +: 4];
    end

    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_CONVERT;
          shift_d = value_in;
          acc_d   = '0;
          iter_d  = '0;
        end
      end
      S_CONVERT: begin
        acc_d   = {acc_adj[18:0], shift_q[15]};
        shift_d = {shift_q[14:0], 1'b0};
        iter_d  = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          // The finished result goes straight to the display register in one
          // write, so the scanner never sees a half-updated digit set.
          disp_d  = acc_d;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Digit scanner
  // ---------------------------------------------------------------------------
  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  // Output registers are fed from the next-state index and next display
  // value, so an_n and digit_bin stay consistent and a fresh result shows
  // on the enabled digit in the same cycle done pulses.
  always_comb begin
    nib       = 4'h0;
    lead_zero = 1'b0;
    case (idx_d)
      3'd0: begin nib = disp_d[3:0];   lead_zero = 1'b0;                  end
      3'd1: begin nib = disp_d[7:4];   lead_zero = (disp_d[19:4]  == '0); end
      3'd2: begin nib = disp_d[11:8];  lead_zero = (disp_d[19:8]  == '0); end
      3'd3: begin nib = disp_d[15:12]; lead_zero = (disp_d[19:12] == '0); end
      3'd4: begin nib = disp_d[19:16]; lead_zero = (disp_d[19:16] == '0); end
      default: begin nib = 4'h0;       lead_zero = 1'b0;                  end
    endcase
    digit_d = ((BLANK_LEADING != 0) && lead_zero) ? 4'hF : nib;
    an_n_d  = ~(5'b00001 << idx_d);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      disp_q  <= '0;
      done_q  <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      an_n_q  <= 5'b11110;
      digit_q <= 4'h0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      an_n_q  <= an_n_d;
      digit_q <= digit_d;
    end
  end

  assign busy      = (state_q == S_CONVERT);
  assign done      = done_q;
  assign digit_bin = digit_q;
  assign an_n      = an_n_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
//
// Scoreboard bench for seven_seg_scan_ctrl. Stimulus pushes the expected
// scanned digit codes (digit k in bits [4k+3:4k]) when it issues a load; a
// monitor pops them on every done pulse and compares the scanned digits.
// A second instance with BLANK_LEADING = 0 covers the unblanked display.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

  localparam int RD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in, value_b;
  logic        load, load_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [3:0]  digit_a, digit_b;
  logic [4:0]  an_n_a, an_n_b;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_LEADING(1)) dut_a (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .busy(busy_a), .done(done_a), .digit_bin(digit_a), .an_n(an_n_a)
  );

  seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_LEADING(0)) dut_b (
    .clk(clk), .rst(rst), .value_in(value_b), .load(load_b),
    .busy(busy_b), .done(done_b), .digit_bin(digit_b), .an_n(an_n_b)
  );

  int          checks   = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          bad_an   = 0;
  int          stray    = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Samples 11 consecutive negedges (covers a full refresh at RD = 2) and
  // collects the digit code shown while each anode is enabled.
  task automatic scan(input bit sel, output logic [19:0] got, output logic [4:0] seen);
    got  = '0;
    seen = '0;
    for (int i = 0; i < 11; i++) begin
      logic [4:0] a;
      logic [3:0] d;
      int         k;
      a = sel ? an_n_b  : an_n_a;
      d = sel ? digit_b : digit_a;
      case (a)
        5'b11110: k = 0;
        5'b11101: k = 1;
        5'b11011: k = 2;
        5'b10111: k = 3;
        5'b01111: k = 4;
        default:  k = -1;
      endcase
      if (k < 0) bad_an++;
      else begin
        got[4*k +: 4] = d;
        seen[k]       = 1'b1;
      end
      if (i < 10) @(negedge clk);
    end
  endtask

  task automatic check_digits(input string tag, input logic [19:0] got,
                              input logic [4:0] seen, input logic [19:0] req);
    for (int k = 0; k < 5; k++)
      check($sformatf("%s_digit%0d", tag, k), got[4*k +: 4], req[4*k +: 4]);
    check({tag, "_seen"}, seen, 5'h1F);
  endtask

  // Monitor: every done pulse is matched against the oldest pending load.
  initial begin
    logic [19:0] req, got;
    logic [4:0]  seen;
    forever begin
      @(negedge clk);
      if (!rst && done_a === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 required no pending load");
        end else begin
          req = exp_q.pop_front();
          scan(1'b0, got, seen);
          check_digits($sformatf("mon_%05h", req), got, seen, req);
        end
      end
    end
  end

  // Load a value and time busy/done; the monitor checks the digits.
  task automatic load_and_check(input logic [15:0] v, input logic [19:0] req, input string tag);
    int n;
    @(negedge clk);
    check({tag, "_idle"}, busy_a, 1'b0);
    exp_q.push_back(req);
    value_in = v;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n    = 0;
    while (busy_a === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, n, 16);
    check({tag, "_done"}, done_a, 1'b1);
    @(negedge clk);
    check({tag, "_done_once"}, done_a, 1'b0);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  an_tab [11];
    logic [3:0]  dig_tab[11];
    logic [19:0] got;
    logic [4:0]  seen;
    int          d0, n;

    an_tab  = '{5'b11110, 5'b11110, 5'b11101, 5'b11101, 5'b11011, 5'b11011,
                5'b10111, 5'b10111, 5'b01111, 5'b01111, 5'b11110};
    dig_tab = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};

    rst      = 1'b1;
    load     = 1'b0;
    load_b   = 1'b0;
    value_in = '0;
    value_b  = '0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    check("rst_busy",  busy_a,  1'b0);
    check("rst_done",  done_a,  1'b0);
    check("rst_an_n",  an_n_a,  5'b11110);
    check("rst_digit", digit_a, 4'h0);
    rst = 1'b0;

    // Free-running scan after reset, two cycles per digit.
    for (int i = 0; i < 11; i++) begin
      check($sformatf("scan_an_n_%0d", i),  an_n_a,  an_tab[i]);
      check($sformatf("scan_digit_%0d", i), digit_a, dig_tab[i]);
      @(negedge clk);
    end

    load_and_check(16'd12345, 20'h12345, "v12345");
    load_and_check(16'd0,     20'hFFFF0, "v0");
    load_and_check(16'd65535, 20'h65535, "v65535");
    load_and_check(16'd10005, 20'h10005, "v10005");

    // Loads during CONVERT are ignored; a load in N+17 is accepted.
    @(negedge clk);
    d0 = done_cnt;
    exp_q.push_back(20'hFF777);
    value_in = 16'd777;
    load     = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      load     = (c == 3 || c == 10 || c == 17);
      value_in = load ? 16'd999 : 16'd777;
      if (c == 3 || c == 10) check($sformatf("ign_busy_c%0d", c), busy_a, 1'b1);
      if (c == 17) begin
        check("ign_busy_c17", busy_a, 1'b0);
        check("ign_done_c17", done_a, 1'b1);
        exp_q.push_back(20'hFF999);
      end
      if (c == 34) begin
        check("ign_done_c34", done_a, 1'b1);
        check("ign_busy_c34", busy_a, 1'b0);
      end
      if (c != 17 && c != 34 && done_a === 1'b1) stray++;
    end
    load = 1'b0;
    @(negedge clk);
    check("ign_done_count", done_cnt - d0, 2);
    repeat (12) @(negedge clk);

    // Reset mid-conversion: no done, display back to zero.
    @(negedge clk);
    d0       = done_cnt;
    value_in = 16'd500;
    load     = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (c == 8) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_done", done_a, 1'b0);
    check("midrst_an_n", an_n_a, 5'b11110);
    scan(1'b0, got, seen);
    check_digits("midrst", got, seen, 20'hFFFF0);
    check("midrst_no_done", done_cnt - d0, 0);
    load_and_check(16'd500, 20'hFF500, "v500");

    // Unblanked instance.
    @(negedge clk);
    value_b = 16'd42;
    load_b  = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    n      = 0;
    while (done_b !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("b42_latency", n, 16);
    scan(1'b1, got, seen);
    check_digits("b42", got, seen, 20'h00042);

    repeat (4) @(negedge clk);
    check("pending_loads", exp_q.size(), 0);
    check("stray_done",    stray,        0);
    check("an_n_onehot",   bad_an,       0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
